decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I + RETIRQ/MASKIRQ decoder with a one-deep registered control bundle and
// single-level interrupt entry. Define DECODE_STAGE_TRAP_EN to enable the trap bundle.
// Custom-0 opcode 7'b0001011: funct3 0 = RETIRQ (jump to q0), funct3 1 = MASKIRQ (mask <= rs1).
module decode_stage #(
  parameter int unsigned NUM_IRQ        = 4,
  parameter logic [31:0] IRQ_VEC_BASE   = 32'h10,
  parameter logic [31:0] IRQ_VEC_STRIDE = 32'h4
) (
  input  logic               clk,
  input  logic               reset_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [31:0]        instr_i,
  input  logic [31:0]        pc_i,
  output logic [5:0]         reg_out1_sel_o,
  output logic [5:0]         reg_out2_sel_o,
  input  logic [31:0]        reg_out1_i,
  input  logic [31:0]        reg_out2_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [1:0]         next_pc_sel_o,
  output logic [1:0]         reg_in_source_o,
  output logic [5:0]         reg_in_sel_o,
  output logic               reg_in_en_o,
  output logic [2:0]         alu_op_o,
  output logic               alu_op_qual_o,
  output logic               alu_op_ext_o,
  output logic               d_we_o,
  output logic               addr_valid_o,
  output logic [31:0]        addr_o,
  output logic [31:0]        imm_o,
  output logic               alu_in1_sel_o,
  output logic               alu_in2_sel_o,
  output logic [3:0]         mask_o,
  output logic               sext_o,
  output logic               eoi_o,
  output logic               trap_o,
  output logic [4:0]         irq_id_o
);

`ifdef DECODE_STAGE_TRAP_EN
  localparam logic TrapEn = 1'b1;
`else
  localparam logic TrapEn = 1'b0;
`endif

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpReg     = 7'b0110011;
  localparam logic [6:0] OpFence   = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpCustom0 = 7'b0001011;

  typedef struct packed {
    logic [1:0]  next_pc_sel;
    logic [1:0]  reg_in_source;
    logic [5:0]  reg_in_sel;
    logic        reg_in_en;
    logic [2:0]  alu_op;
    logic        alu_op_qual;
    logic        alu_op_ext;
    logic        d_we;
    logic        addr_valid;
    logic [31:0] addr;
    logic [31:0] imm;
    logic        alu_in1_sel;
    logic        alu_in2_sel;
    logic [3:0]  mask;
    logic        sext;
    logic        eoi;
    logic        trap;
  } bundle_t;

  function automatic bundle_t nop_bundle();
    bundle_t b;
    b      = '0;
    b.mask = 4'b1111;
    return b;
  endfunction

  function automatic logic [4:0] lowest_idx(input logic [NUM_IRQ-1:0] req);
    logic [4:0] idx;
    idx = 5'd0;
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      if (req[k]) idx = 5'(k);
      else        idx = idx;
    end
    return idx;
  endfunction

  logic [6:0]         opcode_s;
  logic [2:0]         funct3_s;
  logic [5:0]         rd_sel_s;
  logic [31:0]        imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic               illegal_s, taken_s, trap_s;
  logic               is_retirq_s, is_maskirq_s;
  logic               ready_o_s, irq_take_s, xfer_s;
  logic [NUM_IRQ-1:0] pend_s, irq_onehot_s;
  logic [4:0]         irq_idx_s;
  bundle_t            base_s, dec_s, irq_bundle_s;

  bundle_t            bundle_q, bundle_d;
  logic               valid_q, valid_d;
  logic [4:0]         irq_id_q, irq_id_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               in_service_q, in_service_d;
  logic [4:0]         id_q, id_d;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];
  assign rd_sel_s = {1'b0, instr_i[11:7]};
  assign imm_i_s  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_s  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u_s  = {instr_i[31:12], 12'd0};
  assign imm_j_s  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // LUI reads x0 so the ALU sees 0 + imm; RETIRQ reads the saved return address in q0.
  always_comb begin
    reg_out2_sel_o = {1'b0, instr_i[24:20]};
    if (opcode_s == OpLui) begin
      reg_out1_sel_o = 6'd0;
    end else if ((opcode_s == OpCustom0) && (funct3_s == 3'b000)) begin
      reg_out1_sel_o = 6'd32;
    end else begin
      reg_out1_sel_o = {1'b0, instr_i[19:15]};
    end
  end

  // Base instruction decode; illegal_s marks encodings that become NOP or trap.
  always_comb begin
    base_s       = nop_bundle();
    illegal_s    = 1'b0;
    taken_s      = 1'b0;
    is_retirq_s  = 1'b0;
    is_maskirq_s = 1'b0;
    case (opcode_s)
      OpLui, OpAuipc: begin
        base_s.reg_in_sel  = rd_sel_s;
        base_s.reg_in_en   = 1'b1;
        base_s.imm         = imm_u_s;
        base_s.alu_in1_sel = (opcode_s == OpAuipc);
        base_s.alu_in2_sel = 1'b1;
      end
      OpJal: begin
        base_s.reg_in_source = 2'd2;
        base_s.reg_in_sel    = rd_sel_s;
        base_s.reg_in_en     = 1'b1;
        base_s.next_pc_sel   = 2'd1;
        base_s.addr          = imm_j_s;
        base_s.imm           = imm_j_s;
      end
      OpJalr: begin
        base_s.reg_in_source = 2'd2;
        base_s.reg_in_sel    = rd_sel_s;
        base_s.reg_in_en     = 1'b1;
        base_s.next_pc_sel   = 2'd3;
        base_s.addr          = (reg_out1_i + imm_i_s) & 32'hFFFF_FFFE;
        base_s.imm           = imm_i_s;
      end
      OpBranch: begin
        case (funct3_s)
          3'b000:  taken_s = (reg_out1_i == reg_out2_i);
          3'b001:  taken_s = (reg_out1_i != reg_out2_i);
          3'b100:  taken_s = ($signed(reg_out1_i) <  $signed(reg_out2_i));
          3'b101:  taken_s = ($signed(reg_out1_i) >= $signed(reg_out2_i));
          3'b110:  taken_s = (reg_out1_i <  reg_out2_i);
          3'b111:  taken_s = (reg_out1_i >= reg_out2_i);
          default: illegal_s = 1'b1;
        endcase
        base_s.next_pc_sel = taken_s ? 2'd1 : 2'd0;
        base_s.addr        = imm_b_s;
        base_s.imm         = imm_b_s;
      end
      OpLoad: begin
        base_s.reg_in_source = 2'd1;
        base_s.reg_in_sel    = rd_sel_s;
        base_s.reg_in_en     = 1'b1;
        base_s.addr_valid    = 1'b1;
        base_s.addr          = reg_out1_i + imm_i_s;
        base_s.imm           = imm_i_s;
        case (funct3_s)
          3'b000:  begin base_s.mask = 4'b0001; base_s.sext = 1'b1; end
          3'b001:  begin base_s.mask = 4'b0011; base_s.sext = 1'b1; end
          3'b010:  base_s.mask = 4'b1111;
          3'b100:  base_s.mask = 4'b0001;
          3'b101:  base_s.mask = 4'b0011;
          default: illegal_s = 1'b1;
        endcase
      end
      OpStore: begin
        base_s.d_we       = 1'b1;
        base_s.addr_valid = 1'b1;
        base_s.addr       = reg_out1_i + imm_s_s;
        base_s.imm        = imm_s_s;
        case (funct3_s)
          3'b000:  base_s.mask = 4'b0001;
          3'b001:  base_s.mask = 4'b0011;
          3'b010:  base_s.mask = 4'b1111;
          default: illegal_s = 1'b1;
        endcase
      end
      OpImm, OpReg: begin
        base_s.reg_in_sel  = rd_sel_s;
        base_s.reg_in_en   = 1'b1;
        base_s.alu_op      = funct3_s;
        base_s.alu_in2_sel = (opcode_s == OpImm);
        base_s.imm         = (opcode_s == OpImm) ? imm_i_s : 32'd0;
        if (opcode_s == OpReg) begin
          base_s.alu_op_qual = instr_i[30];
          base_s.alu_op_ext  = instr_i[25];
        end else begin
          base_s.alu_op_qual = (funct3_s == 3'b101) & instr_i[30];
          base_s.alu_op_ext  = 1'b0;
        end
      end
      OpCustom0: begin
        case (funct3_s)
          3'b000: begin
            is_retirq_s        = 1'b1;
            base_s.next_pc_sel = 2'd3;
            base_s.addr        = reg_out1_i & 32'hFFFF_FFFE;
            base_s.eoi         = 1'b1;
          end
          3'b001:  is_maskirq_s = 1'b1;
          default: illegal_s = 1'b1;
        endcase
      end
      OpFence: base_s = nop_bundle();
      OpSystem: begin
        illegal_s = (instr_i == 32'h0000_0073) || (instr_i == 32'h0010_0073);
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign trap_s = TrapEn & illegal_s;

  // Final decode selection: trap bundle, NOP for illegal encodings, or the base decode.
  always_comb begin
    dec_s = base_s;
    if (trap_s) begin
      dec_s               = nop_bundle();
      dec_s.reg_in_source = 2'd3;
      dec_s.reg_in_sel    = 6'd33;
      dec_s.reg_in_en     = 1'b1;
      dec_s.next_pc_sel   = 2'd3;
      dec_s.addr          = 32'h0000_0008;
      dec_s.imm           = pc_i;
      dec_s.trap          = 1'b1;
    end else if (illegal_s) begin
      dec_s = nop_bundle();
    end else begin
      dec_s = base_s;
    end
  end

  assign pend_s     = pending_q & ~mask_q;
  assign irq_idx_s  = lowest_idx(pend_s);
  assign ready_o_s  = ~valid_q | ready_i;
  assign irq_take_s = valid_i & ready_o_s & ~in_service_q & (|pend_s);
  assign xfer_s     = valid_i & ready_o_s & ~irq_take_s;
  assign ready_o    = ready_o_s;

  // Interrupt entry bundle; imm carries the interrupted PC that lands in q0.
  always_comb begin
    irq_onehot_s = '0;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      irq_onehot_s[k] = (irq_idx_s == 5'(k));
    end
    irq_bundle_s               = nop_bundle();
    irq_bundle_s.reg_in_source = 2'd3;
    irq_bundle_s.reg_in_sel    = 6'd32;
    irq_bundle_s.reg_in_en     = 1'b1;
    irq_bundle_s.next_pc_sel   = 2'd3;
    irq_bundle_s.addr          = IRQ_VEC_BASE + ({27'd0, irq_idx_s} * IRQ_VEC_STRIDE);
    irq_bundle_s.imm           = pc_i;
  end

  // Next-state for output register and interrupt controller; pending set beats clear.
  always_comb begin
    bundle_d     = bundle_q;
    valid_d      = valid_q;
    irq_id_d     = irq_id_q;
    pending_d    = pending_q | irq_i;
    in_service_d = in_service_q;
    id_d         = id_q;
    mask_d       = mask_q;
    if (irq_take_s) begin
      bundle_d     = irq_bundle_s;
      valid_d      = 1'b1;
      irq_id_d     = irq_idx_s;
      pending_d    = (pending_q & ~irq_onehot_s) | irq_i;
      in_service_d = 1'b1;
      id_d         = irq_idx_s;
    end else if (xfer_s) begin
      bundle_d = dec_s;
      valid_d  = 1'b1;
      irq_id_d = 5'd0;
      if (is_retirq_s) begin
        irq_id_d     = in_service_q ? id_q : 5'd0;
        in_service_d = 1'b0;
      end else if (is_maskirq_s) begin
        mask_d = reg_out1_i[NUM_IRQ-1:0];
      end else begin
        mask_d = mask_q;
      end
    end else if (ready_o_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers; reset leaves every line masked and the bundle empty.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      bundle_q     <= nop_bundle();
      valid_q      <= 1'b0;
      irq_id_q     <= 5'd0;
      pending_q    <= '0;
      in_service_q <= 1'b0;
      id_q         <= 5'd0;
      mask_q       <= '1;
    end else begin
      bundle_q     <= bundle_d;
      valid_q      <= valid_d;
      irq_id_q     <= irq_id_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      id_q         <= id_d;
      mask_q       <= mask_d;
    end
  end

  assign valid_o         = valid_q;
  assign irq_id_o        = irq_id_q;
  assign next_pc_sel_o   = bundle_q.next_pc_sel;
  assign reg_in_source_o = bundle_q.reg_in_source;
  assign reg_in_sel_o    = bundle_q.reg_in_sel;
  assign reg_in_en_o     = bundle_q.reg_in_en;
  assign alu_op_o        = bundle_q.alu_op;
  assign alu_op_qual_o   = bundle_q.alu_op_qual;
  assign alu_op_ext_o    = bundle_q.alu_op_ext;
  assign d_we_o          = bundle_q.d_we;
  assign addr_valid_o    = bundle_q.addr_valid;
  assign addr_o          = bundle_q.addr;
  assign imm_o           = bundle_q.imm;
  assign alu_in1_sel_o   = bundle_q.alu_in1_sel;
  assign alu_in2_sel_o   = bundle_q.alu_in2_sel;
  assign mask_o          = bundle_q.mask;
  assign sext_o          = bundle_q.sext;
  assign eoi_o           = bundle_q.eoi;
  assign trap_o          = bundle_q.trap;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, branches, interrupt entry/return, stall and reset.
module tb_decode_stage;
  localparam logic [31:0] ADDI   = 32'hFFF0_8293;
  localparam logic [31:0] BLT    = 32'h0020_C463;
  localparam logic [31:0] BLTU   = 32'h0020_E463;
  localparam logic [31:0] LW     = 32'h0040_A183;
  localparam logic [31:0] JALR   = 32'h0051_00E7;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] RETIRQ = 32'h0000_000B;
  localparam logic [31:0] MASKIR = 32'h0000_100B;

  logic        clk = 1'b0;
  logic        reset_ni, valid_i, ready_o, ready_i, valid_o;
  logic [31:0] instr_i, pc_i, reg_out1_i, reg_out2_i, addr_o, imm_o;
  logic [5:0]  reg_out1_sel_o, reg_out2_sel_o, reg_in_sel_o;
  logic [3:0]  irq_i, mask_o;
  logic [1:0]  next_pc_sel_o, reg_in_source_o;
  logic        reg_in_en_o, alu_op_qual_o, alu_op_ext_o, d_we_o, addr_valid_o;
  logic        alu_in1_sel_o, alu_in2_sel_o, sext_o, eoi_o, trap_o;
  logic [2:0]  alu_op_o;
  logic [4:0]  irq_id_o;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage dut (
    .clk(clk), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .reg_out1_sel_o(reg_out1_sel_o), .reg_out2_sel_o(reg_out2_sel_o),
    .reg_out1_i(reg_out1_i), .reg_out2_i(reg_out2_i), .irq_i(irq_i), .valid_o(valid_o),
    .ready_i(ready_i), .next_pc_sel_o(next_pc_sel_o), .reg_in_source_o(reg_in_source_o),
    .reg_in_sel_o(reg_in_sel_o), .reg_in_en_o(reg_in_en_o), .alu_op_o(alu_op_o),
    .alu_op_qual_o(alu_op_qual_o), .alu_op_ext_o(alu_op_ext_o), .d_we_o(d_we_o),
    .addr_valid_o(addr_valid_o), .addr_o(addr_o), .imm_o(imm_o), .alu_in1_sel_o(alu_in1_sel_o),
    .alu_in2_sel_o(alu_in2_sel_o), .mask_o(mask_o), .sext_o(sext_o), .eoi_o(eoi_o),
    .trap_o(trap_o), .irq_id_o(irq_id_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    valid_i    = v;
    instr_i    = ins;
    reg_out1_i = r1;
    reg_out2_i = r2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b0; ready_i = 1'b1; irq_i = 4'd0; pc_i = 32'h40;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #23;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_mask", 32'(mask_o), 32'hF);
    chk("rst_en", 32'(reg_in_en_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    reset_ni = 1'b1;

    drive(1'b1, ADDI, 32'h7, 32'h0);
    #1;
    chk("addi_rs1sel", 32'(reg_out1_sel_o), 32'd1);
    tick();
    chk("addi_valid", 32'(valid_o), 32'd1);
    chk("addi_rd", 32'(reg_in_sel_o), 32'd5);
    chk("addi_imm", imm_o, 32'hFFFF_FFFF);
    chk("addi_in2", 32'(alu_in2_sel_o), 32'd1);
    chk("addi_en", 32'(reg_in_en_o), 32'd1);

    drive(1'b1, BLT, 32'hFFFF_FFFF, 32'h1);
    tick();
    chk("blt_npc", 32'(next_pc_sel_o), 32'd1);
    chk("blt_addr", addr_o, 32'h8);
    drive(1'b1, BLTU, 32'hFFFF_FFFF, 32'h1);
    tick();
    chk("bltu_npc", 32'(next_pc_sel_o), 32'd0);

    drive(1'b1, ECALL, 32'h0, 32'h0);
    tick();
    chk("ecall_valid", 32'(valid_o), 32'd1);
`ifdef DECODE_STAGE_TRAP_EN
    chk("ecall_trap", 32'(trap_o), 32'd1);
    chk("ecall_addr", addr_o, 32'h8);
    chk("ecall_rd", 32'(reg_in_sel_o), 32'd33);
`else
    chk("ecall_trap", 32'(trap_o), 32'd0);
    chk("ecall_en", 32'(reg_in_en_o), 32'd0);
    chk("ecall_npc", 32'(next_pc_sel_o), 32'd0);
`endif

    drive(1'b1, JALR, 32'h100, 32'h0);
    tick();
    chk("jalr_addr", addr_o, 32'h104);
    chk("jalr_npc", 32'(next_pc_sel_o), 32'd3);
    chk("jalr_src", 32'(reg_in_source_o), 32'd2);

    drive(1'b1, RETIRQ, 32'h201, 32'h0);
    #1;
    chk("ret_sel", 32'(reg_out1_sel_o), 32'd32);
    tick();
    chk("ret0_eoi", 32'(eoi_o), 32'd1);
    chk("ret0_id", 32'(irq_id_o), 32'd0);
    chk("ret0_addr", addr_o, 32'h200);

    drive(1'b1, MASKIR, 32'h0, 32'h0);
    tick();
    chk("mask_en", 32'(reg_in_en_o), 32'd0);
    drive(1'b0, ADDI, 32'h7, 32'h0);
    irq_i = 4'b0110;
    tick();
    chk("idle_valid", 32'(valid_o), 32'd0);
    irq_i = 4'b0000;
    drive(1'b1, ADDI, 32'h7, 32'h0);
    #1;
    chk("take_ready", 32'(ready_o), 32'd1);
    tick();
    chk("irq1_src", 32'(reg_in_source_o), 32'd3);
    chk("irq1_rd", 32'(reg_in_sel_o), 32'd32);
    chk("irq1_npc", 32'(next_pc_sel_o), 32'd3);
    chk("irq1_addr", addr_o, 32'h14);
    chk("irq1_id", 32'(irq_id_o), 32'd1);
    tick();
    chk("replay_rd", 32'(reg_in_sel_o), 32'd5);
    chk("replay_id", 32'(irq_id_o), 32'd0);
    tick();
    chk("nonest_src", 32'(reg_in_source_o), 32'd0);
    drive(1'b1, RETIRQ, 32'h101, 32'h0);
    tick();
    chk("ret1_eoi", 32'(eoi_o), 32'd1);
    chk("ret1_id", 32'(irq_id_o), 32'd1);
    chk("ret1_addr", addr_o, 32'h100);
    drive(1'b1, ADDI, 32'h7, 32'h0);
    tick();
    chk("irq2_addr", addr_o, 32'h18);
    chk("irq2_id", 32'(irq_id_o), 32'd2);
    tick();
    drive(1'b1, RETIRQ, 32'h300, 32'h0);
    tick();
    chk("ret2_id", 32'(irq_id_o), 32'd2);

    drive(1'b1, LW, 32'h1000, 32'h0);
    irq_i = 4'b0001;
    tick();
    irq_i = 4'b0000;
    chk("lw_src", 32'(reg_in_source_o), 32'd1);
    chk("lw_addr", addr_o, 32'h1004);
    chk("lw_mask", 32'(mask_o), 32'hF);
    ready_i = 1'b0;
    drive(1'b1, ADDI, 32'h7, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 32'(ready_o), 32'd0);
      tick();
      chk("stall_addr", addr_o, 32'h1004);
      chk("stall_src", 32'(reg_in_source_o), 32'd1);
      chk("stall_valid", 32'(valid_o), 32'd1);
    end
    ready_i = 1'b1;
    tick();
    chk("irq0_addr", addr_o, 32'h10);
    chk("irq0_rd", 32'(reg_in_sel_o), 32'd32);

    #2;
    reset_ni = 1'b0;
    #2;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_mask", 32'(mask_o), 32'hF);
    chk("arst_en", 32'(reg_in_en_o), 32'd0);
    reset_ni = 1'b1;
    irq_i = 4'b0001;
    tick();
    tick();
    chk("masked_src", 32'(reg_in_source_o), 32'd0);
    chk("masked_id", 32'(irq_id_o), 32'd0);
    irq_i = 4'b0000;
    drive(1'b1, MASKIR, 32'h0, 32'h0);
    tick();
    drive(1'b1, ADDI, 32'h7, 32'h0);
    tick();
    chk("unmask_addr", addr_o, 32'h10);
    chk("unmask_src", 32'(reg_in_source_o), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
